// File: rtl/nn_pkg.sv
// Shared fixed-point sample definitions for the pooling/NN datapath.
package nn_pkg;
  localparam int INTEGER_BITS     = 9;
  localparam int FIXED_POINT_BITS = 4;
  localparam int SAMPLE_W         = INTEGER_BITS + FIXED_POINT_BITS;
  localparam int DEF_IN_DIM       = 12;
  localparam int DEF_POOL_DIM     = DEF_IN_DIM / 2;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // Ties return a, so the earlier operand wins when values are equal.
  function automatic sample_t smax(sample_t a, sample_t b);
    return (b > a) ? b : a;
  endfunction
endpackage

// File: rtl/max_pool_streamer_if.sv
// Conv-sample input and pooled-sample output stream; no backpressure.
interface max_pool_streamer_if import nn_pkg::*; ();
  sample_t conv_output;
  logic    conv_output_valid;
  sample_t pool_output;
  logic    pool_output_valid;
  logic    frame_done;

  modport master (output conv_output, conv_output_valid,
                  input  pool_output, pool_output_valid, frame_done);
  modport slave  (input  conv_output, conv_output_valid,
                  output pool_output, pool_output_valid, frame_done);
endinterface

// File: rtl/pool_line_buffer.sv
// Holds one row of horizontal pair maxima until the matching odd row arrives.
module pool_line_buffer import nn_pkg::*; #(
  parameter int DEPTH = DEF_POOL_DIM,
  parameter int AW    = 3
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  sample_t       wdata,
  input  logic [AW-1:0] raddr,
  output sample_t       rdata
);
  sample_t mem [DEPTH];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/max_pool_streamer.sv
// 2x2 stride-2 max pool with optional ReLU over a raster-scan feature map.
module max_pool_streamer import nn_pkg::*; #(
  parameter int IN_DIM  = DEF_IN_DIM,
  parameter bit RELU_EN = 1'b1
) (
  input logic i_clk,
  input logic i_reset,
  max_pool_streamer_if.slave bus
);
  localparam int POOL_DIM = IN_DIM / 2;
  localparam int N_OUT    = POOL_DIM * POOL_DIM;
  localparam int CW       = (IN_DIM > 1)   ? $clog2(IN_DIM)   : 1;
  localparam int AW       = (POOL_DIM > 1) ? $clog2(POOL_DIM) : 1;
  localparam int OW       = (N_OUT > 1)    ? $clog2(N_OUT)    : 1;

  logic [CW-1:0] in_col, in_row;
  logic [OW-1:0] out_cnt;
  logic [AW-1:0] lb_idx;
  sample_t       pair_reg, pair_max, lb_rd, win_max, result;
  logic          accept, lb_we, emit;

  assign accept = bus.conv_output_valid;
  assign lb_idx = AW'(in_col >> 1);
  assign lb_we  = accept &  in_col[0] & ~in_row[0];
  assign emit   = accept &  in_col[0] &  in_row[0];

  always_comb begin
    pair_max = smax(pair_reg, bus.conv_output);
    win_max  = smax(lb_rd, pair_max);
    result   = (RELU_EN && (win_max < 0)) ? '0 : win_max;
  end

  pool_line_buffer #(.DEPTH(POOL_DIM), .AW(AW)) u_lb (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .we      (lb_we),
    .waddr   (lb_idx),
    .wdata   (pair_max),
    .raddr   (lb_idx),
    .rdata   (lb_rd)
  );

  // Raster position of the next sample; wraps straight into the next frame.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      in_col <= '0;
      in_row <= '0;
    end else if (accept) begin
      if (in_col == CW'(IN_DIM - 1)) begin
        in_col <= '0;
        in_row <= (in_row == CW'(IN_DIM - 1)) ? '0 : in_row + 1'b1;
      end else begin
        in_col <= in_col + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                  pair_reg <= '0;
    else if (accept && !in_col[0]) pair_reg <= bus.conv_output;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      bus.pool_output       <= '0;
      bus.pool_output_valid <= 1'b0;
      bus.frame_done        <= 1'b0;
      out_cnt               <= '0;
    end else begin
      bus.pool_output_valid <= emit;
      bus.frame_done        <= emit && (out_cnt == OW'(N_OUT - 1));
      if (emit) begin
        bus.pool_output <= result;
        out_cnt         <= (out_cnt == OW'(N_OUT - 1)) ? '0 : out_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_max_pool_streamer.sv
// Drives two instances (ReLU on/off) with directed and random frames and
// scores them against a window-max reference model.
module tb_max_pool_streamer;
  import nn_pkg::*;

  localparam int D = 12;
  localparam int P = D / 2;

  logic    i_clk = 1'b0;
  logic    i_reset;
  sample_t din;
  logic    dval;

  max_pool_streamer_if b1 ();
  max_pool_streamer_if b0 ();

  assign b1.conv_output       = din;
  assign b1.conv_output_valid = dval;
  assign b0.conv_output       = din;
  assign b0.conv_output_valid = dval;

  max_pool_streamer #(.IN_DIM(D), .RELU_EN(1'b1)) dut1 (
    .i_clk(i_clk), .i_reset(i_reset), .bus(b1));
  max_pool_streamer #(.IN_DIM(D), .RELU_EN(1'b0)) dut0 (
    .i_clk(i_clk), .i_reset(i_reset), .bus(b0));

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    sample_t v1;
    sample_t v0;
    logic    fd;
    int      due;
  } exp_t;

  exp_t    exp_q[$];
  int      checks = 0;
  int      errors = 0;
  int      fd_cnt = 0;
  sample_t img [D][D];

  function automatic sample_t relu(sample_t x);
    return (x < 0) ? sample_t'(0) : x;
  endfunction

  // Scoreboard: every valid pulse must match the oldest expected window,
  // arriving exactly on the cycle after its closing sample.
  always @(negedge i_clk) begin
    if (b1.pool_output_valid) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_out got %h want none", b1.pool_output);
      end
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        if (b1.frame_done) fd_cnt++;
        checks += 5;
        assert (cyc === e.due) else begin
          errors++; $error("FAIL latency got cyc %0d want %0d", cyc, e.due);
        end
        assert (b1.pool_output === e.v1) else begin
          errors++; $error("FAIL relu_out got %h want %h", b1.pool_output, e.v1);
        end
        assert (b0.pool_output === e.v0) else begin
          errors++; $error("FAIL raw_out got %h want %h", b0.pool_output, e.v0);
        end
        assert (b0.pool_output_valid === 1'b1) else begin
          errors++; $error("FAIL raw_valid got %b want 1", b0.pool_output_valid);
        end
        assert (b1.frame_done === e.fd && b0.frame_done === e.fd) else begin
          errors++; $error("FAIL frame_done got %b/%b want %b", b1.frame_done, b0.frame_done, e.fd);
        end
      end
    end else begin
      checks++;
      assert (b0.pool_output_valid === 1'b0 && b1.frame_done === 1'b0 && b0.frame_done === 1'b0) else begin
        errors++;
        $error("FAIL idle_outputs got v0=%b fd=%b/%b want 0", b0.pool_output_valid, b1.frame_done, b0.frame_done);
      end
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        errors++;
        $error("FAIL missing_out got none want %h (due %0d)", exp_q[0].v1, exp_q[0].due);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      dval = 1'b0;
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic send(input sample_t v);
    din  = v;
    dval = 1'b1;
    @(posedge i_clk);
    #1;
    dval = 1'b0;
  endtask

  // kind: 0 ramp, 1 all -1.0, 2 random, 3 single window in a -1.0 field
  task automatic fill(input int kind);
    for (int r = 0; r < D; r++)
      for (int c = 0; c < D; c++)
        case (kind)
          0:       img[r][c] = sample_t'(16 * (r * D + c));
          2:       img[r][c] = sample_t'($urandom);
          default: img[r][c] = 13'h1FF0;
        endcase
    if (kind == 3) begin
      img[0][0] = 13'h1FD0;
      img[0][1] = 13'h0028;
      img[1][0] = 13'h0008;
      img[1][1] = 13'h0028;
    end
  endtask

  task automatic play(input int max_gap, input bit ramp_chk, input int stop_after,
                      input bit first_chk, input sample_t f1, input sample_t f0);
    for (int r = 0; r < D; r++)
      for (int c = 0; c < D; c++) begin
        if (stop_after >= 0 && (r * D + c) >= stop_after) return;
        if (max_gap > 0) idle($urandom_range(0, max_gap));
        send(img[r][c]);
        if ((r % 2) == 1 && (c % 2) == 1) begin
          exp_t    e;
          sample_t m;
          int      k;
          m = img[r-1][c-1];
          for (int dr = -1; dr <= 0; dr++)
            for (int dc = -1; dc <= 0; dc++)
              if (img[r+dr][c+dc] > m) m = img[r+dr][c+dc];
          k     = (r / 2) * P + (c / 2);
          e.v1  = relu(m);
          e.v0  = m;
          e.fd  = (k == P * P - 1);
          e.due = cyc;
          exp_q.push_back(e);
          if (ramp_chk) begin
            sample_t want;
            want = sample_t'(16 * (24 * (k / 6) + 2 * (k % 6) + 13));
            checks++;
            assert (b1.pool_output === want) else begin
              errors++; $error("FAIL ramp_k%0d got %h want %h", k, b1.pool_output, want);
            end
          end
          if (first_chk && k == 0) begin
            checks++;
            assert (b1.pool_output === f1 && b0.pool_output === f0) else begin
              errors++;
              $error("FAIL first_out got %h/%h want %h/%h", b1.pool_output, b0.pool_output, f1, f0);
            end
          end
        end
      end
  endtask

  initial begin
    din     = '0;
    dval    = 1'b0;
    i_reset = 1'b1;
    #1;
    checks++;
    assert (b1.pool_output === '0 && b1.pool_output_valid === 1'b0 && b1.frame_done === 1'b0 &&
            b0.pool_output === '0 && b0.pool_output_valid === 1'b0 && b0.frame_done === 1'b0) else begin
      errors++; $error("FAIL reset_state got %h/%b want 0/0", b1.pool_output, b1.pool_output_valid);
    end
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    idle(2);

    fill(0); play(0, 1'b1, -1, 1'b1, 13'h00D0, 13'h00D0); idle(3);
    fill(1); play(0, 1'b0, -1, 1'b1, 13'h0000, 13'h1FF0); idle(3);
    fill(3); play(0, 1'b0, -1, 1'b1, 13'h0028, 13'h0028); idle(3);
    fill(0); play(3, 1'b1, -1, 1'b0, '0, '0); idle(3);

    checks++;
    assert (fd_cnt === 4) else begin
      errors++; $error("FAIL fd_count_a got %0d want 4", fd_cnt);
    end
    fill(2); play(0, 1'b0, -1, 1'b0, '0, '0);
    fill(2); play(0, 1'b0, -1, 1'b0, '0, '0);
    idle(3);
    checks++;
    assert (fd_cnt === 6) else begin
      errors++; $error("FAIL fd_count_b2b got %0d want 6", fd_cnt);
    end

    // Partial frame, then reset asserted between clock edges.
    fill(0); play(0, 1'b0, 50, 1'b0, '0, '0);
    i_reset = 1'b1;
    #1;
    checks++;
    assert (b1.pool_output === '0 && b0.pool_output === '0 &&
            b1.pool_output_valid === 1'b0 && b0.frame_done === 1'b0) else begin
      errors++; $error("FAIL async_reset got %h/%h want 0/0", b1.pool_output, b0.pool_output);
    end
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    fill(0); play(0, 1'b1, -1, 1'b1, 13'h00D0, 13'h00D0);
    idle(4);

    checks += 2;
    assert (exp_q.size() === 0) else begin
      errors++; $error("FAIL drain got %0d pending want 0", exp_q.size());
    end
    assert (fd_cnt === 7) else begin
      errors++; $error("FAIL fd_count_total got %0d want 7", fd_cnt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
